lcd_face_engine: RTL and testbench
==================================

Name: lcd_face_engine

Overview:
- Custom-character face painter for an HD44780/LCD1602 in 8-bit mode, plus a statistics change detector.
- Painter path: on request, loads the 4 CGRAM glyphs of the selected face, then places them as a 2x2 block at DDRAM columns 0-1 of both rows.
- Detector path: raises new_update whenever face or any statistic changes.
- Sits beside the LCD controller. The controller muxes rs/data to this block while it paints, and polls new_update.

Parameters:
- NUM_FACES, 9, number of faces in the glyph ROM.
- MAX_VALUE, 5, maximum statistic value; statistic width is $clog2(MAX_VALUE).
- HOLD_CYCLES, 1600000, clk cycles new_update stays high after a change (one full clk_16ms period).

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-low reset.
- clk_16ms  in  1  LCD enable square wave; sampled as data and rising-edge detected, never used as a clock.
- num_cust_char  in  $clog2(NUM_FACES)  face to paint.
- start_painting  in  1  level request.
- lcd_available  out  1  1 = idle/ready, 0 = painting.
- rs  out  1  LCD register select.
- rw  out  1  constant 0.
- data  out  8  LCD data bus.
- face  in  $clog2(NUM_FACES)  current face (detector).
- Hunger, Joy, Energy  in  $clog2(MAX_VALUE) each  statistics (detector).
- new_update  out  1  change flag.

Behaviour:
- Clock and reset:
  - Single clock clk; reset is synchronous, active-low.
  - Reset values: lcd_available=1, rs=0, data=8'h00, new_update=0, step counter=0. Detector snapshot loads the current inputs.
  - Reset mid-paint aborts immediately to idle.
- Tick:
  - tick = one-clk pulse on each rising edge of clk_16ms, from a 2-flop synchroniser plus edge detect.
  - All painter output changes happen 2-3 clk cycles after the clk_16ms rise, so they are stable well before the falling edge of enable.
- Painter FSM: IDLE -> SEND -> DONE -> IDLE.
  - IDLE: lcd_available=1, rs=0, data=0x00.
  - IDLE -> SEND: on a tick with start_painting=1, latch the face (an index >= NUM_FACES is clamped to 0), set lcd_available=0 and drive step 0.
  - SEND: one byte per tick, 39 steps:
    - step 0: rs=0, data=0x40 (CGRAM address 0).
    - steps 1-32: rs=1, data={3'b000, FACE_ROM[face][step-1][4:0]}; glyph g rows 0-7 sit at ROM index g*8+row.
    - step 33: rs=0, data=0x80.
    - step 34: rs=1, data=0x00.
    - step 35: rs=1, data=0x01.
    - step 36: rs=0, data=0xC0.
    - step 37: rs=1, data=0x02.
    - step 38: rs=1, data=0x03.
  - DONE: on the tick after step 38, rs=0, data=0x00, lcd_available=1.
  - start_painting is ignored while painting. A level still high at idle retriggers on the next tick.
- Detector:
  - Holds a registered snapshot of {face, Hunger, Joy, Energy}.
  - When the inputs differ from the snapshot: update the snapshot, set new_update=1 and load the hold counter with HOLD_CYCLES.
  - The counter decrements each clk; new_update clears when it reaches 0.
  - A further change during the hold reloads the counter.
  - Simultaneous changes produce a single event.

Decomposition:
- Package lcd_face_pkg holds:
  - LCD command constants: CGRAM_BASE 0x40, DDRAM_ROW0 0x80, DDRAM_ROW1 0xC0.
  - FACE_GLYPH_BYTES=32.
  - PAINT_STEPS=39.
  - FACE_ROM constant [NUM_FACES][32][5]; face 0 = idle face.
- Sub-module stat_change_detector implements the detector path. The painter stays in the top.

Test Plan:
- Reset, then release with start_painting=0 and clk_16ms toggling -> lcd_available=1, rs=0, data=0x00, rw=0, new_update=0.
- start_painting=1, num_cust_char=3 at a tick -> lcd_available drops within 3 clks. Bytes per tick:
  - 0x40/rs0;
  - 32 bytes equal to FACE_ROM[3] with rs1;
  - 0x80/rs0, 0x00, 0x01/rs1;
  - 0xC0/rs0, 0x02, 0x03/rs1.
  - Then lcd_available=1 on tick 40.
- Pulse start_painting during step 10 of a face-0 paint -> sequence unchanged, no restart, 39 bytes total.
- num_cust_char=12 with NUM_FACES=9 -> data bytes equal FACE_ROM[0].
- Hunger 5 -> 4 -> new_update=1 for exactly HOLD_CYCLES clks (use HOLD_CYCLES=20). Changing Joy at cycle 10 extends it to cycle 30.
- Assert reset=0 at step 20 of a paint -> next clk shows lcd_available=1, data=0x00. A subsequent start paints from step 0.

Source files
------------

// File: rtl/lcd_face_pkg.sv
// lcd_face_pkg: shared constants, types, glyph ROM and byte-sequence helper for
// the LCD face painter.
//   CGRAM_BASE / DDRAM_ROW0 / DDRAM_ROW1 : HD44780 address-set commands
//   FACE_ROM[face][g*8+row]              : 5-bit glyph rows, 4 glyphs per face
//   paint_byte(face, step)               : {rs, data} for one paint step
package lcd_face_pkg;

  localparam int unsigned ROM_FACES        = 9;
  localparam int unsigned FACE_IDX_W       = $clog2(ROM_FACES);
  localparam int unsigned FACE_GLYPH_BYTES = 32;
  localparam int unsigned PAINT_STEPS      = 39;
  localparam int unsigned STEP_W           = $clog2(PAINT_STEPS);

  localparam logic [7:0] CGRAM_BASE = 8'h40;
  localparam logic [7:0] DDRAM_ROW0 = 8'h80;
  localparam logic [7:0] DDRAM_ROW1 = 8'hC0;

  typedef enum logic [1:0] {
    PAINT_IDLE,
    PAINT_SEND,
    PAINT_DONE
  } paint_state_e;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_byte_t;

  // Glyph order: 0 top-left, 1 top-right, 2 bottom-left, 3 bottom-right.
  localparam logic [4:0] FACE_ROM [ROM_FACES][FACE_GLYPH_BYTES] = '{
    // 0: idle
    '{5'h00, 5'h03, 5'h04, 5'h08, 5'h09, 5'h08, 5'h08, 5'h08,
      5'h00, 5'h18, 5'h04, 5'h02, 5'h12, 5'h02, 5'h02, 5'h02,
      5'h08, 5'h08, 5'h08, 5'h0F, 5'h08, 5'h04, 5'h03, 5'h00,
      5'h02, 5'h02, 5'h02, 5'h1E, 5'h02, 5'h04, 5'h18, 5'h00},
    // 1: happy
    '{5'h00, 5'h03, 5'h04, 5'h08, 5'h09, 5'h08, 5'h08, 5'h08,
      5'h00, 5'h18, 5'h04, 5'h02, 5'h12, 5'h02, 5'h02, 5'h02,
      5'h08, 5'h0A, 5'h09, 5'h08, 5'h08, 5'h04, 5'h03, 5'h00,
      5'h02, 5'h0A, 5'h12, 5'h02, 5'h02, 5'h04, 5'h18, 5'h00},
    // 2: sad
    '{5'h00, 5'h03, 5'h04, 5'h08, 5'h09, 5'h08, 5'h08, 5'h08,
      5'h00, 5'h18, 5'h04, 5'h02, 5'h12, 5'h02, 5'h02, 5'h02,
      5'h08, 5'h08, 5'h09, 5'h0A, 5'h08, 5'h04, 5'h03, 5'h00,
      5'h02, 5'h02, 5'h12, 5'h0A, 5'h02, 5'h04, 5'h18, 5'h00},
    // 3: hungry
    '{5'h00, 5'h03, 5'h04, 5'h08, 5'h0B, 5'h08, 5'h08, 5'h08,
      5'h00, 5'h18, 5'h04, 5'h02, 5'h1A, 5'h02, 5'h02, 5'h02,
      5'h08, 5'h09, 5'h0A, 5'h0A, 5'h09, 5'h04, 5'h03, 5'h00,
      5'h02, 5'h12, 5'h0A, 5'h0A, 5'h12, 5'h04, 5'h18, 5'h00},
    // 4: sleepy
    '{5'h00, 5'h03, 5'h04, 5'h08, 5'h08, 5'h0B, 5'h08, 5'h08,
      5'h00, 5'h18, 5'h04, 5'h02, 5'h02, 5'h1A, 5'h02, 5'h02,
      5'h08, 5'h08, 5'h08, 5'h09, 5'h08, 5'h04, 5'h03, 5'h00,
      5'h02, 5'h02, 5'h02, 5'h12, 5'h02, 5'h04, 5'h18, 5'h00},
    // 5: excited
    '{5'h00, 5'h03, 5'h04, 5'h09, 5'h0B, 5'h09, 5'h08, 5'h08,
      5'h00, 5'h18, 5'h04, 5'h12, 5'h1A, 5'h12, 5'h02, 5'h02,
      5'h08, 5'h0B, 5'h0A, 5'h09, 5'h08, 5'h04, 5'h03, 5'h00,
      5'h02, 5'h1A, 5'h0A, 5'h12, 5'h02, 5'h04, 5'h18, 5'h00},
    // 6: tired
    '{5'h00, 5'h03, 5'h04, 5'h08, 5'h0F, 5'h08, 5'h08, 5'h08,
      5'h00, 5'h18, 5'h04, 5'h02, 5'h1E, 5'h02, 5'h02, 5'h02,
      5'h08, 5'h08, 5'h0B, 5'h08, 5'h08, 5'h04, 5'h03, 5'h00,
      5'h02, 5'h02, 5'h1A, 5'h02, 5'h02, 5'h04, 5'h18, 5'h00},
    // 7: angry
    '{5'h00, 5'h03, 5'h04, 5'h0A, 5'h09, 5'h08, 5'h08, 5'h08,
      5'h00, 5'h18, 5'h04, 5'h0A, 5'h12, 5'h02, 5'h02, 5'h02,
      5'h08, 5'h08, 5'h09, 5'h0A, 5'h08, 5'h04, 5'h03, 5'h00,
      5'h02, 5'h02, 5'h12, 5'h0A, 5'h02, 5'h04, 5'h18, 5'h00},
    // 8: sick
    '{5'h00, 5'h03, 5'h05, 5'h08, 5'h0A, 5'h08, 5'h08, 5'h08,
      5'h00, 5'h18, 5'h14, 5'h02, 5'h0A, 5'h02, 5'h02, 5'h02,
      5'h08, 5'h0E, 5'h08, 5'h0E, 5'h08, 5'h04, 5'h03, 5'h00,
      5'h02, 5'h0E, 5'h02, 5'h0E, 5'h02, 5'h04, 5'h18, 5'h00}
  };

  // Byte emitted at a given paint step: CGRAM load, then the 2x2 DDRAM block.
  function automatic lcd_byte_t paint_byte(input logic [FACE_IDX_W-1:0] face,
                                           input logic [STEP_W-1:0]     step);
    lcd_byte_t b;
    b.rs   = 1'b1;
    b.data = 8'h00;
    if (step == STEP_W'(0)) begin
      b.rs   = 1'b0;
      b.data = CGRAM_BASE;
    end else if (step <= STEP_W'(FACE_GLYPH_BYTES)) begin
      b.data = {3'b000, FACE_ROM[face][5'(step - STEP_W'(1))]};
    end else begin
      case (step)
        STEP_W'(33): begin b.rs = 1'b0; b.data = DDRAM_ROW0; end
        STEP_W'(34): b.data = 8'h00;
        STEP_W'(35): b.data = 8'h01;
        STEP_W'(36): begin b.rs = 1'b0; b.data = DDRAM_ROW1; end
        STEP_W'(37): b.data = 8'h02;
        STEP_W'(38): b.data = 8'h03;
        default:     begin b.rs = 1'b0; b.data = 8'h00; end
      endcase
    end
    return b;
  endfunction

endpackage

// File: rtl/lcd_face_engine_stat_change_detector.sv
// stat_change_detector: flags any change of a packed statistics word and holds
// new_update high for HOLD_CYCLES clk cycles after the latest change.
//   clk, reset (sync, active-low) ; stats in [W] ; new_update out
module stat_change_detector #(
  parameter int unsigned W           = 13,
  parameter int unsigned HOLD_CYCLES = 1600000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] stats,
  output logic         new_update
);

  localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);

  logic [W-1:0]     snap_q;
  logic [CNT_W-1:0] hold_q;

  // Counter is loaded with HOLD_CYCLES-1 and the flag drops on the cycle after
  // it hits zero, giving exactly HOLD_CYCLES high cycles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      snap_q     <= stats;
      hold_q     <= '0;
      new_update <= 1'b0;
    end else if (stats != snap_q) begin
      snap_q     <= stats;
      hold_q     <= CNT_W'(HOLD_CYCLES - 1);
      new_update <= 1'b1;
    end else if (new_update) begin
      if (hold_q == '0) new_update <= 1'b0;
      else              hold_q     <= hold_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/lcd_face_engine.sv
// lcd_face_engine: paints a 2x2 custom-character face on an HD44780 (8-bit
// mode), one byte per clk_16ms rising edge, and detects statistic changes.
//   clk, reset (sync, active-low), clk_16ms (sampled enable wave)
//   num_cust_char, start_painting -> lcd_available, rs, rw, data
//   face, Hunger, Joy, Energy     -> new_update
module lcd_face_engine
  import lcd_face_pkg::*;
#(
  parameter int unsigned NUM_FACES   = 9,
  parameter int unsigned MAX_VALUE   = 5,
  parameter int unsigned HOLD_CYCLES = 1600000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clk_16ms,
  input  logic [$clog2(NUM_FACES)-1:0] num_cust_char,
  input  logic                         start_painting,
  output logic                         lcd_available,
  output logic                         rs,
  output logic                         rw,
  output logic [7:0]                   data,
  input  logic [$clog2(NUM_FACES)-1:0] face,
  input  logic [$clog2(MAX_VALUE)-1:0] Hunger,
  input  logic [$clog2(MAX_VALUE)-1:0] Joy,
  input  logic [$clog2(MAX_VALUE)-1:0] Energy,
  output logic                         new_update
);

  localparam int unsigned STATS_W = $clog2(NUM_FACES) + 3 * $clog2(MAX_VALUE);

  paint_state_e          state_q;
  logic [STEP_W-1:0]     step_q;
  logic [FACE_IDX_W-1:0] face_q;
  logic [2:0]            sync_q;
  logic                  tick_c;
  logic [FACE_IDX_W-1:0] face_sel_c;
  lcd_byte_t             next_byte_c;

  assign rw = 1'b0;

  // Two-flop synchroniser in [1:0], edge-detect delay in [2].
  assign tick_c = sync_q[1] & ~sync_q[2];

  // Out-of-range face requests fall back to the idle face.
  assign face_sel_c = (32'(num_cust_char) >= NUM_FACES || 32'(num_cust_char) >= ROM_FACES)
                      ? '0 : FACE_IDX_W'(num_cust_char);

  assign next_byte_c = paint_byte(face_q, step_q + STEP_W'(1));

  // Painter FSM; every output is registered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q        <= '0;
      state_q       <= PAINT_IDLE;
      step_q        <= '0;
      face_q        <= '0;
      lcd_available <= 1'b1;
      rs            <= 1'b0;
      data          <= 8'h00;
    end else begin
      sync_q <= {sync_q[1:0], clk_16ms};
      case (state_q)
        PAINT_IDLE: begin
          if (tick_c && start_painting) begin
            face_q        <= face_sel_c;
            step_q        <= '0;
            lcd_available <= 1'b0;
            rs            <= 1'b0;
            data          <= CGRAM_BASE;
            state_q       <= PAINT_SEND;
          end
        end
        PAINT_SEND: begin
          if (tick_c) begin
            if (step_q == STEP_W'(PAINT_STEPS - 1)) begin
              step_q        <= '0;
              lcd_available <= 1'b1;
              rs            <= 1'b0;
              data          <= 8'h00;
              state_q       <= PAINT_DONE;
            end else begin
              step_q <= step_q + STEP_W'(1);
              rs     <= next_byte_c.rs;
              data   <= next_byte_c.data;
            end
          end
        end
        PAINT_DONE: state_q <= PAINT_IDLE;
        default:    state_q <= PAINT_IDLE;
      endcase
    end
  end

  stat_change_detector #(
    .W           (STATS_W),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_detector (
    .clk        (clk),
    .reset      (reset),
    .stats      ({face, Hunger, Joy, Energy}),
    .new_update (new_update)
  );

endmodule

// File: tb/tb_lcd_face_engine.sv
// tb_lcd_face_engine: directed self-checking bench for lcd_face_engine.
module tb_lcd_face_engine;

  localparam int unsigned HOLD = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       clk_16ms;
  logic [3:0] num_cust_char;
  logic       start_painting;
  logic       lcd_available;
  logic       rs;
  logic       rw;
  logic [7:0] data;
  logic [3:0] face;
  logic [2:0] Hunger, Joy, Energy;
  logic       new_update;

  int checks = 0;
  int errors = 0;

  logic       s_av, s_rs;
  logic [7:0] s_data;

  // Independent copies of the glyph rows for faces 0 and 3.
  localparam logic [4:0] TB_FACE0 [32] = '{
    5'h00, 5'h03, 5'h04, 5'h08, 5'h09, 5'h08, 5'h08, 5'h08,
    5'h00, 5'h18, 5'h04, 5'h02, 5'h12, 5'h02, 5'h02, 5'h02,
    5'h08, 5'h08, 5'h08, 5'h0F, 5'h08, 5'h04, 5'h03, 5'h00,
    5'h02, 5'h02, 5'h02, 5'h1E, 5'h02, 5'h04, 5'h18, 5'h00};
  localparam logic [4:0] TB_FACE3 [32] = '{
    5'h00, 5'h03, 5'h04, 5'h08, 5'h0B, 5'h08, 5'h08, 5'h08,
    5'h00, 5'h18, 5'h04, 5'h02, 5'h1A, 5'h02, 5'h02, 5'h02,
    5'h08, 5'h09, 5'h0A, 5'h0A, 5'h09, 5'h04, 5'h03, 5'h00,
    5'h02, 5'h12, 5'h0A, 5'h0A, 5'h12, 5'h04, 5'h18, 5'h00};

  lcd_face_engine #(
    .NUM_FACES   (9),
    .MAX_VALUE   (5),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .clk_16ms       (clk_16ms),
    .num_cust_char  (num_cust_char),
    .start_painting (start_painting),
    .lcd_available  (lcd_available),
    .rs             (rs),
    .rw             (rw),
    .data           (data),
    .face           (face),
    .Hunger         (Hunger),
    .Joy            (Joy),
    .Energy         (Energy),
    .new_update     (new_update)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One enable period: rise, sample outputs 3 clks later, then fall.
  task automatic tick16();
    @(negedge clk) clk_16ms = 1'b1;
    repeat (3) @(negedge clk);
    s_av   = lcd_available;
    s_rs   = rs;
    s_data = data;
    clk_16ms = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  // Expected {lcd_available, rs, data} after the k-th tick of a paint (k from 0).
  function automatic logic [9:0] exp_word(input int k, input int f);
    logic [4:0] row;
    row = 5'h00;
    if (k >= 1 && k <= 32) row = (f == 3) ? TB_FACE3[5'(k - 1)] : TB_FACE0[5'(k - 1)];
    if (k == 0)       return {1'b0, 1'b0, 8'h40};
    else if (k <= 32) return {1'b0, 1'b1, 3'b000, row};
    else if (k == 33) return {1'b0, 1'b0, 8'h80};
    else if (k == 34) return {1'b0, 1'b1, 8'h00};
    else if (k == 35) return {1'b0, 1'b1, 8'h01};
    else if (k == 36) return {1'b0, 1'b0, 8'hC0};
    else if (k == 37) return {1'b0, 1'b1, 8'h02};
    else if (k == 38) return {1'b0, 1'b1, 8'h03};
    else              return {1'b1, 1'b0, 8'h00};
  endfunction

  // Full paint: ticks 1..40; start held for the first tick, optional mid-paint pulse.
  task automatic run_paint(input string tag, input int f, input int pulse_at);
    for (int k = 0; k <= 39; k++) begin
      if (k == pulse_at) start_painting = 1'b1;
      tick16();
      if (k == 0 || k == pulse_at) start_painting = 1'b0;
      check($sformatf("%s_t%0d", tag, k + 1), 16'({s_av, s_rs, s_data}), 16'(exp_word(k, f)));
    end
  endtask

  // new_update pattern after a change at sample 0; optional Joy change at joy_at.
  task automatic run_hold(input string tag, input int n, input int last_high, input int joy_at);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      check($sformatf("%s_c%0d", tag, i), 16'(new_update), 16'(i <= last_high));
      if (i == joy_at) Joy = Joy + 3'd1;
    end
  endtask

  initial begin
    reset = 1'b0; clk_16ms = 1'b0; start_painting = 1'b0; num_cust_char = 4'd0;
    face = 4'd0; Hunger = 3'd5; Joy = 3'd3; Energy = 3'd2;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_avail", 16'(lcd_available), 16'd1);
    check("rst_rs",    16'(rs),            16'd0);
    check("rst_data",  16'(data),          16'h00);
    check("rst_rw",    16'(rw),            16'd0);
    check("rst_upd",   16'(new_update),    16'd0);
    reset = 1'b1;

    // Idle with enable toggling and no request
    tick16();
    tick16();
    check("idle_word", 16'({s_av, s_rs, s_data}), 16'({1'b1, 1'b0, 8'h00}));
    check("idle_upd",  16'(new_update), 16'd0);

    // Face 3 paint
    num_cust_char = 4'd3;
    start_painting = 1'b1;
    run_paint("f3", 3, -1);

    // Face 0 paint with a request pulse at step 10, then no restart
    num_cust_char = 4'd0;
    start_painting = 1'b1;
    run_paint("f0", 0, 10);
    tick16();
    check("f0_norestart", 16'({s_av, s_rs, s_data}), 16'({1'b1, 1'b0, 8'h00}));

    // Out-of-range face clamps to face 0
    num_cust_char = 4'd12;
    start_painting = 1'b1;
    run_paint("clamp", 0, -1);

    // Reset at step 20 aborts; a new request starts from step 0
    num_cust_char = 4'd3;
    start_painting = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      tick16();
      start_painting = 1'b0;
    end
    check("abort_s20", 16'({s_av, s_rs, s_data}), 16'(exp_word(20, 3)));
    reset = 1'b0;
    @(negedge clk);
    check("abort_avail", 16'(lcd_available), 16'd1);
    check("abort_data",  16'(data),          16'h00);
    check("abort_rs",    16'(rs),            16'd0);
    reset = 1'b1;
    start_painting = 1'b1;
    tick16();
    start_painting = 1'b0;
    check("restart_s0", 16'({s_av, s_rs, s_data}), 16'(exp_word(0, 3)));
    tick16();
    check("restart_s1", 16'({s_av, s_rs, s_data}), 16'(exp_word(1, 3)));

    // Detector: single change holds for HOLD cycles
    @(negedge clk);
    check("det_quiet", 16'(new_update), 16'd0);
    Hunger = 3'd4;
    run_hold("hold", HOLD + 5, HOLD, -1);

    // Detector: second change at cycle 10 extends to cycle 30
    Hunger = 3'd3;
    run_hold("ext", 35, 30, 10);

    // Detector: simultaneous changes give one event
    Hunger = 3'd2;
    Energy = 3'd1;
    run_hold("simul", HOLD + 5, HOLD, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
